// File: rtl/axi_slave_ram.sv
// axi_slave_ram: single-port-per-direction AXI4 slave backed by a 2**AWIDTH x 32-bit RAM.
// Every burst is treated as INCR with a 4-byte step. Read and write channels run independent
// FSMs; a same-cycle write and read of one word returns the old contents.
// Optional build macro AXI_RAM_DECERR_EN: when defined, beats whose address bits above the
// RAM are nonzero are out of range (writes dropped, reads return 0, responses 2'b11).
// When undefined, the upper address bits are ignored and the word index wraps inside a burst.
module axi_slave_ram #(
    parameter int AWIDTH = 10
) (
    input  logic        clk,
    input  logic        rst,
    // write address channel
    input  logic        s_axi_AWVALID,
    output logic        s_axi_AWREADY,
    input  logic [63:0] s_axi_AWADDR,
    input  logic        s_axi_AWID,
    input  logic [7:0]  s_axi_AWLEN,
    // write data channel
    input  logic        s_axi_WVALID,
    output logic        s_axi_WREADY,
    input  logic [31:0] s_axi_WDATA,
    input  logic [3:0]  s_axi_WSTRB,
    input  logic        s_axi_WLAST,
    // write response channel
    output logic        s_axi_BVALID,
    input  logic        s_axi_BREADY,
    output logic [1:0]  s_axi_BRESP,
    output logic        s_axi_BID,
    // read address channel
    input  logic        s_axi_ARVALID,
    output logic        s_axi_ARREADY,
    input  logic [63:0] s_axi_ARADDR,
    input  logic        s_axi_ARID,
    input  logic [7:0]  s_axi_ARLEN,
    // read data channel
    output logic        s_axi_RVALID,
    input  logic        s_axi_RREADY,
    output logic [31:0] s_axi_RDATA,
    output logic        s_axi_RLAST,
    output logic [1:0]  s_axi_RRESP,
    output logic        s_axi_RID
);

    localparam int DEPTH = 2 ** AWIDTH;
    // Width of the tracked word address: the full 62-bit word address when range checking
    // is compiled in, otherwise only the bits that index the RAM (so the index wraps).
`ifdef AXI_RAM_DECERR_EN
    localparam int AK = 62;
`else
    localparam int AK = AWIDTH;
`endif

    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wstate_t;
    typedef enum logic {R_IDLE, R_DATA} rstate_t;

    logic [31:0] mem [0:DEPTH-1];

    // ---------------- write side state ----------------
    wstate_t     wstate_q, wstate_d;
    logic        awready_q, awready_d;
    logic        wready_q, wready_d;
    logic        bvalid_q, bvalid_d;
    logic [AK-1:0] waddr_q, waddr_d;
    logic [7:0]  wlen_q, wlen_d;
    logic [7:0]  wcnt_q, wcnt_d;
    logic        werr_q, werr_d;
    logic [1:0]  bresp_q, bresp_d;
    logic        bid_q, bid_d;

    // ---------------- read side state ----------------
    rstate_t     rstate_q, rstate_d;
    logic        arready_q, arready_d;
    logic        rvalid_q, rvalid_d;
    logic [AK-1:0] raddr_q, raddr_d;
    logic [7:0]  rlen_q, rlen_d;
    logic [7:0]  rcnt_q, rcnt_d;
    logic        rlast_q, rlast_d;
    logic        rid_q, rid_d;
    logic [1:0]  rresp_q, rresp_d;
    logic [31:0] rdata_q;

    logic        rd_en;
    logic [AK-1:0] rd_addr;
    logic        rd_oob;

    logic aw_hs, w_hs, b_hs, ar_hs, r_hs;
    logic [AWIDTH-1:0] w_idx;
    logic [AWIDTH-1:0] rd_idx;
    logic w_oob;
    logic [3:0] we_lane;

    assign aw_hs = s_axi_AWVALID && awready_q;
    assign w_hs  = s_axi_WVALID  && wready_q;
    assign b_hs  = bvalid_q      && s_axi_BREADY;
    assign ar_hs = s_axi_ARVALID && arready_q;
    assign r_hs  = rvalid_q      && s_axi_RREADY;

    assign w_idx  = waddr_q[AWIDTH-1:0];
    assign rd_idx = rd_addr[AWIDTH-1:0];

`ifdef AXI_RAM_DECERR_EN
    assign w_oob = |waddr_q[AK-1:AWIDTH];
`else
    assign w_oob = 1'b0;
`endif

    // Per-lane write enables; a beat coinciding with reset is abandoned, not written.
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            assign we_lane[gi] = w_hs && !rst && !w_oob && s_axi_WSTRB[gi];
        end
    endgenerate

    // Write FSM next-state: address phase, data beats, then one response.
    always_comb begin
        wstate_d = wstate_q;
        waddr_d  = waddr_q;
        wlen_d   = wlen_q;
        wcnt_d   = wcnt_q;
        werr_d   = werr_q;
        bresp_d  = bresp_q;
        bid_d    = bid_q;
        case (wstate_q)
            W_IDLE: begin
                if (aw_hs) begin
                    wstate_d = W_DATA;
                    waddr_d  = s_axi_AWADDR[AK+1:2];
                    wlen_d   = s_axi_AWLEN;
                    wcnt_d   = 8'd0;
                    werr_d   = 1'b0;
                    bid_d    = s_axi_AWID;
                end
            end
            W_DATA: begin
                if (w_hs) begin
                    waddr_d = waddr_q + AK'(1);
                    wcnt_d  = wcnt_q + 8'd1;
                    werr_d  = werr_q | w_oob;
                    if (wcnt_q == wlen_q) begin
                        wstate_d = W_RESP;
                        bresp_d  = (werr_q | w_oob) ? 2'b11 : 2'b00;
                    end
                end
            end
            W_RESP: begin
                if (b_hs) begin
                    wstate_d = W_IDLE;
                end
            end
            default: wstate_d = W_IDLE;
        endcase
        awready_d = (wstate_d == W_IDLE);
        wready_d  = (wstate_d == W_DATA);
        bvalid_d  = (wstate_d == W_RESP);
    end

    // Write FSM registers; reset abandons any burst and clears the handshake outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            wstate_q  <= W_IDLE;
            awready_q <= 1'b0;
            wready_q  <= 1'b0;
            bvalid_q  <= 1'b0;
            waddr_q   <= '0;
            wlen_q    <= 8'd0;
            wcnt_q    <= 8'd0;
            werr_q    <= 1'b0;
            bresp_q   <= 2'b00;
            bid_q     <= 1'b0;
        end else begin
            wstate_q  <= wstate_d;
            awready_q <= awready_d;
            wready_q  <= wready_d;
            bvalid_q  <= bvalid_d;
            waddr_q   <= waddr_d;
            wlen_q    <= wlen_d;
            wcnt_q    <= wcnt_d;
            werr_q    <= werr_d;
            bresp_q   <= bresp_d;
            bid_q     <= bid_d;
        end
    end

    // Read FSM next-state plus RAM read-port control. RDATA is prefetched on the AR
    // handshake and on every non-last R handshake so beats stream without bubbles.
    always_comb begin
        rstate_d = rstate_q;
        raddr_d  = raddr_q;
        rlen_d   = rlen_q;
        rcnt_d   = rcnt_q;
        rlast_d  = rlast_q;
        rid_d    = rid_q;
        rresp_d  = rresp_q;
        rd_en    = 1'b0;
        rd_addr  = raddr_q;
        case (rstate_q)
            R_IDLE: begin
                if (ar_hs) begin
                    rstate_d = R_DATA;
                    rd_en    = 1'b1;
                    rd_addr  = s_axi_ARADDR[AK+1:2];
                    raddr_d  = s_axi_ARADDR[AK+1:2] + AK'(1);
                    rlen_d   = s_axi_ARLEN;
                    rcnt_d   = 8'd0;
                    rlast_d  = (s_axi_ARLEN == 8'd0);
                    rid_d    = s_axi_ARID;
                end
            end
            R_DATA: begin
                if (r_hs) begin
                    if (rlast_q) begin
                        rstate_d = R_IDLE;
                        rlast_d  = 1'b0;
                    end else begin
                        rd_en   = 1'b1;
                        raddr_d = raddr_q + AK'(1);
                        rcnt_d  = rcnt_q + 8'd1;
                        rlast_d = ((rcnt_q + 8'd1) == rlen_q);
                    end
                end
            end
            default: rstate_d = R_IDLE;
        endcase
`ifdef AXI_RAM_DECERR_EN
        rd_oob = |rd_addr[AK-1:AWIDTH];
`else
        rd_oob = 1'b0;
`endif
        if (rd_en) begin
            rresp_d = rd_oob ? 2'b11 : 2'b00;
        end
        arready_d = (rstate_d == R_IDLE);
        rvalid_d  = (rstate_d == R_DATA);
    end

    // Read FSM registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            rstate_q  <= R_IDLE;
            arready_q <= 1'b0;
            rvalid_q  <= 1'b0;
            raddr_q   <= '0;
            rlen_q    <= 8'd0;
            rcnt_q    <= 8'd0;
            rlast_q   <= 1'b0;
            rid_q     <= 1'b0;
            rresp_q   <= 2'b00;
        end else begin
            rstate_q  <= rstate_d;
            arready_q <= arready_d;
            rvalid_q  <= rvalid_d;
            raddr_q   <= raddr_d;
            rlen_q    <= rlen_d;
            rcnt_q    <= rcnt_d;
            rlast_q   <= rlast_d;
            rid_q     <= rid_d;
            rresp_q   <= rresp_d;
        end
    end

    // RAM write port with byte enables; contents are never reset.
    always_ff @(posedge clk) begin
        for (int b = 0; b < 4; b++) begin
            if (we_lane[b]) begin
                mem[w_idx][8*b +: 8] <= s_axi_WDATA[8*b +: 8];
            end
        end
    end

    // Registered RAM read port; sees pre-write contents on a same-cycle collision.
    always_ff @(posedge clk) begin
        if (rst) begin
            rdata_q <= 32'd0;
        end else if (rd_en) begin
            rdata_q <= rd_oob ? 32'd0 : mem[rd_idx];
        end
    end

    assign s_axi_AWREADY = awready_q;
    assign s_axi_WREADY  = wready_q;
    assign s_axi_BVALID  = bvalid_q;
    assign s_axi_BRESP   = bresp_q;
    assign s_axi_BID     = bid_q;
    assign s_axi_ARREADY = arready_q;
    assign s_axi_RVALID  = rvalid_q;
    assign s_axi_RDATA   = rdata_q;
    assign s_axi_RLAST   = rlast_q;
    assign s_axi_RRESP   = rresp_q;
    assign s_axi_RID     = rid_q;

    // Inputs the slave deliberately ignores (WLAST, byte offset, and upper bits when unchecked).
    logic unused_ok;
`ifdef AXI_RAM_DECERR_EN
    assign unused_ok = ^{s_axi_WLAST, s_axi_AWADDR[1:0], s_axi_ARADDR[1:0]};
`else
    assign unused_ok = ^{s_axi_WLAST, s_axi_AWADDR[1:0], s_axi_ARADDR[1:0],
                         s_axi_AWADDR[63:AWIDTH+2], s_axi_ARADDR[63:AWIDTH+2]};
`endif

endmodule
